// File: rtl/move_validity_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Package     : reversi_pkg
// Description : Shared Reversi types: cell encoding, ray directions, scanner
//               FSM states and per-direction step deltas.
// Revision    : 1.0 - initial release
// ============================================================================
package reversi_pkg;

  // Cell encoding is {occupied, is_black}
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [1:0] CELL_BLACK = 2'b11;

  typedef enum logic [2:0] {
    DIR_UP         = 3'd0,
    DIR_DOWN       = 3'd1,
    DIR_LEFT       = 3'd2,
    DIR_RIGHT      = 3'd3,
    DIR_UP_LEFT    = 3'd4,
    DIR_DOWN_LEFT  = 3'd5,
    DIR_UP_RIGHT   = 3'd6,
    DIR_DOWN_RIGHT = 3'd7
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_WALK   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Column step for a direction: -1, 0 or +1
  function automatic logic signed [1:0] dx(input dir_t d);
    case (d)
      DIR_LEFT, DIR_UP_LEFT, DIR_DOWN_LEFT:    dx = 2'sb11;
      DIR_RIGHT, DIR_UP_RIGHT, DIR_DOWN_RIGHT: dx = 2'sb01;
      default:                                 dx = 2'sb00;
    endcase
  endfunction

  // Row step for a direction: -1, 0 or +1
  function automatic logic signed [1:0] dy(input dir_t d);
    case (d)
      DIR_UP, DIR_UP_LEFT, DIR_UP_RIGHT:       dy = 2'sb11;
      DIR_DOWN, DIR_DOWN_LEFT, DIR_DOWN_RIGHT: dy = 2'sb01;
      default:                                 dy = 2'sb00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_validity_scanner_ray_stepper.sv
`default_nettype none
// ============================================================================
// Module      : ray_stepper
// Description : Combinational ray step: next position = pos + delta(d), and
//               an on-board flag for the current pos. Coordinates are CW+1
//               bit signed so one step past either edge is always detected.
// Revision    : 1.0 - initial release
// ============================================================================
module ray_stepper
  import reversi_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic signed [CW:0] pos_x,
  input  logic signed [CW:0] pos_y,
  input  dir_t               d,
  output logic signed [CW:0] next_x,
  output logic signed [CW:0] next_y,
  output logic               on_board
);

  localparam logic signed [CW:0] MAX_COORD = (CW+1)'(N - 1);

  logic signed [1:0] dx_w;
  logic signed [1:0] dy_w;

  // Step one cell along the ray and range-check the current position
  always_comb begin
    dx_w     = dx(d);
    dy_w     = dy(d);
    next_x   = pos_x + {{(CW-1){dx_w[1]}}, dx_w};
    next_y   = pos_y + {{(CW-1){dy_w[1]}}, dy_w};
    on_board = !pos_x[CW] && (pos_x <= MAX_COORD) &&
               !pos_y[CW] && (pos_y <= MAX_COORD);
  end

endmodule
`default_nettype wire

// File: rtl/move_validity_scanner.sv
`default_nettype none
// ============================================================================
// Module      : move_validity_scanner
// Description : Sequential Reversi move checker. Latches a board snapshot on
//               start, walks the 8 rays from the target one cell per clock
//               and reports legality, per-direction mask and flip count.
//               Define FLIP_MASK_EN to also build the per-cell flip_mask.
// Revision    : 1.0 - initial release
// ============================================================================
module move_validity_scanner
  import reversi_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N),
  parameter int FW = $clog2(8*N)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [CW-1:0]     x,
  input  logic [CW-1:0]     y,
  input  logic              player_black,
  input  logic [2*N*N-1:0]  board,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [7:0]        dir_mask,
  output logic [FW-1:0]     flip_count,
  output logic [N*N-1:0]    flip_mask
);

  localparam int IW = $clog2(N*N);

  state_t             state_q, state_d;
  dir_t               d_q, d_d;
  logic [CW-1:0]      x_q, x_d, y_q, y_d;
  logic               player_q, player_d;
  logic [2*N*N-1:0]   board_q, board_d;
  logic signed [CW:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [CW-1:0]      run_cnt_q, run_cnt_d;
  logic               busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [7:0]         dir_mask_q, dir_mask_d;
  logic [FW-1:0]      flip_count_q, flip_count_d;

  logic signed [CW:0] rs_pos_x, rs_pos_y, rs_next_x, rs_next_y;
  dir_t               rs_dir;
  logic               rs_on_board;
  logic [IW-1:0]      cell_idx_w;
  logic [1:0]         cell_w;
  logic [1:0]         cells_w [N*N];
  logic               cell_empty_w, cell_opp_w;

  for (genvar i = 0; i < N*N; i++) begin : g_cells
    assign cells_w[i] = board_q[2*i +: 2];
  end

  // The stepper looks at the target in CHECK/NEXT and at the walk position in WALK
  always_comb begin
    rs_pos_x = {1'b0, x_q};
    rs_pos_y = {1'b0, y_q};
    rs_dir   = DIR_UP;
    case (state_q)
      ST_WALK: begin
        rs_pos_x = pos_x_q;
        rs_pos_y = pos_y_q;
        rs_dir   = d_q;
      end
      ST_NEXT: rs_dir = dir_t'(d_q + 3'd1);
      default: ;
    endcase
  end

  ray_stepper #(.N(N), .CW(CW)) u_ray_stepper (
    .pos_x    (rs_pos_x),
    .pos_y    (rs_pos_y),
    .d        (rs_dir),
    .next_x   (rs_next_x),
    .next_y   (rs_next_y),
    .on_board (rs_on_board)
  );

  // Fetch the cell under the stepper position; off-board reads are forced to cell 0
  always_comb begin
    cell_idx_w = '0;
    if (rs_on_board) begin
      cell_idx_w = IW'(int'(rs_pos_y[CW-1:0]) * N + int'(rs_pos_x[CW-1:0]));
    end
    cell_w       = cells_w[cell_idx_w];
    cell_empty_w = (cell_w[1] == CELL_EMPTY[1]);
    cell_opp_w   = (cell_w == (player_q ? CELL_WHITE : CELL_BLACK));
  end

`ifdef FLIP_MASK_EN
  logic [N*N-1:0] cand_q, cand_d, flip_mask_q, flip_mask_d;
`endif

  // Scanner next-state and result computation
  always_comb begin
    state_d      = state_q;
    d_d          = d_q;
    x_d          = x_q;
    y_d          = y_q;
    player_d     = player_q;
    board_d      = board_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    run_cnt_d    = run_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    valid_d      = valid_q;
    dir_mask_d   = dir_mask_q;
    flip_count_d = flip_count_q;
`ifdef FLIP_MASK_EN
    cand_d       = cand_q;
    flip_mask_d  = flip_mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d          = x;
          y_d          = y;
          player_d     = player_black;
          board_d      = board;
          busy_d       = 1'b1;
          valid_d      = 1'b0;
          dir_mask_d   = '0;
          flip_count_d = '0;
`ifdef FLIP_MASK_EN
          flip_mask_d  = '0;
`endif
          state_d      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!cell_empty_w) begin
          done_d  = 1'b1;
          valid_d = 1'b0;
          state_d = ST_FINISH;
        end else begin
          d_d       = DIR_UP;
          run_cnt_d = '0;
          pos_x_d   = rs_next_x;
          pos_y_d   = rs_next_y;
`ifdef FLIP_MASK_EN
          cand_d    = '0;
`endif
          state_d   = ST_WALK;
        end
      end
      ST_WALK: begin
        if (!rs_on_board || cell_empty_w) begin
          state_d = ST_NEXT;
        end else if (cell_opp_w) begin
          run_cnt_d = run_cnt_q + 1'b1;
          pos_x_d   = rs_next_x;
          pos_y_d   = rs_next_y;
`ifdef FLIP_MASK_EN
          cand_d[cell_idx_w] = 1'b1;
`endif
        end else begin
          // Own piece closes the ray; legal only if it bracketed an opponent run
          if (run_cnt_q != '0) begin
            dir_mask_d[d_q] = 1'b1;
            flip_count_d    = flip_count_q + {{(FW-CW){1'b0}}, run_cnt_q};
`ifdef FLIP_MASK_EN
            flip_mask_d     = flip_mask_q | cand_q;
`endif
          end
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (d_q == DIR_DOWN_RIGHT) begin
          done_d  = 1'b1;
          valid_d = |dir_mask_q;
          state_d = ST_FINISH;
        end else begin
          d_d       = dir_t'(d_q + 3'd1);
          run_cnt_d = '0;
          pos_x_d   = rs_next_x;
          pos_y_d   = rs_next_y;
`ifdef FLIP_MASK_EN
          cand_d    = '0;
`endif
          state_d   = ST_WALK;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      d_q          <= DIR_UP;
      x_q          <= '0;
      y_q          <= '0;
      player_q     <= 1'b0;
      board_q      <= '0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      run_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      dir_mask_q   <= '0;
      flip_count_q <= '0;
`ifdef FLIP_MASK_EN
      cand_q       <= '0;
      flip_mask_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      d_q          <= d_d;
      x_q          <= x_d;
      y_q          <= y_d;
      player_q     <= player_d;
      board_q      <= board_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      run_cnt_q    <= run_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      dir_mask_q   <= dir_mask_d;
      flip_count_q <= flip_count_d;
`ifdef FLIP_MASK_EN
      cand_q       <= cand_d;
      flip_mask_q  <= flip_mask_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign valid      = valid_q;
  assign dir_mask   = dir_mask_q;
  assign flip_count = flip_count_q;
`ifdef FLIP_MASK_EN
  assign flip_mask  = flip_mask_q;
`else
  assign flip_mask  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_move_validity_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_validity_scanner
// Description : Self-checking bench for move_validity_scanner (N=8 main
//               instance, N=6 secondary instance). FLIP_MASK_EN aware.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_validity_scanner;

  localparam int N      = 8;
  localparam int CW     = $clog2(N);
  localparam int FW     = $clog2(8*N);
  localparam int BOUND  = 3 + 8*N;
  localparam int N6     = 6;
  localparam int CW6    = $clog2(N6);
  localparam int FW6    = $clog2(8*N6);
  localparam int BOUND6 = 3 + 8*N6;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] WHITE = 2'b10;
  localparam logic [1:0] BLACK = 2'b11;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [CW-1:0]     x, y;
  logic              player_black;
  logic [2*N*N-1:0]  board;
  logic              busy, done, valid;
  logic [7:0]        dir_mask;
  logic [FW-1:0]     flip_count;
  logic [N*N-1:0]    flip_mask;

  logic              start6;
  logic [CW6-1:0]    x6, y6;
  logic              player6;
  logic [2*N6*N6-1:0] board6;
  logic              busy6, done6, valid6;
  logic [7:0]        dir_mask6;
  logic [FW6-1:0]    flip_count6;
  logic [N6*N6-1:0]  flip_mask6;

  always #5 clk = ~clk;

  move_validity_scanner #(.N(N)) dut (
    .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y),
    .player_black(player_black), .board(board), .busy(busy), .done(done),
    .valid(valid), .dir_mask(dir_mask), .flip_count(flip_count), .flip_mask(flip_mask)
  );

  move_validity_scanner #(.N(N6)) dut6 (
    .clk(clk), .resetn(resetn), .start(start6), .x(x6), .y(y6),
    .player_black(player6), .board(board6), .busy(busy6), .done(done6),
    .valid(valid6), .dir_mask(dir_mask6), .flip_count(flip_count6), .flip_mask(flip_mask6)
  );

  typedef struct {
    bit             v;
    logic [7:0]     m;
    int             fc;
    logic [N*N-1:0] fm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   DX[8] = '{0, 0, -1, 1, -1, -1, 1, 1};
  int   DY[8] = '{-1, 1, 0, 0, -1, 1, -1, 1};
  logic [2*N*N-1:0] bd;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endfunction

  function automatic logic [1:0] cell_of(input logic [2*N*N-1:0] b, input int cx, input int cy);
    return b[2*(cy*N+cx) +: 2];
  endfunction

  task automatic put(input int cx, input int cy, input logic [1:0] c);
    bd[2*(cy*N+cx) +: 2] = c;
  endtask

  function automatic logic [2*N*N-1:0] rand_board();
    logic [2*N*N-1:0] b;
    for (int i = 0; i < N*N; i++) begin
      case ($urandom_range(0, 2))
        0:       b[2*i +: 2] = EMPTY;
        1:       b[2*i +: 2] = WHITE;
        default: b[2*i +: 2] = BLACK;
      endcase
    end
    return b;
  endfunction

  // Reference: for each ray count the opponent run and see whether it is capped by an own piece
  function automatic exp_t model(input logic [2*N*N-1:0] b, input int tx, input int ty, input bit pb);
    exp_t e;
    logic [1:0] own, opp, c;
    logic [N*N-1:0] run;
    int cx, cy, n;
    own = pb ? BLACK : WHITE;
    opp = pb ? WHITE : BLACK;
    e.v = 0; e.m = '0; e.fc = 0; e.fm = '0;
    c = cell_of(b, tx, ty);
    if (c[1]) return e;
    for (int d = 0; d < 8; d++) begin
      cx = tx + DX[d]; cy = ty + DY[d]; n = 0; run = '0;
      while (cx >= 0 && cx < N && cy >= 0 && cy < N && cell_of(b, cx, cy) == opp) begin
        n++; run[cy*N+cx] = 1'b1; cx += DX[d]; cy += DY[d];
      end
      if (n > 0 && cx >= 0 && cx < N && cy >= 0 && cy < N && cell_of(b, cx, cy) == own) begin
        e.m[d] = 1'b1; e.fc += n; e.fm |= run; e.v = 1;
      end
    end
`ifndef FLIP_MASK_EN
    e.fm = '0;
`endif
    return e;
  endfunction

  // Compare process: every done pulse is checked against the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        chk("done_without_request", done, 0);
      end else begin
        e = exp_q.pop_front();
        chk("valid", valid, e.v);
        chk("dir_mask", dir_mask, e.m);
        chk("flip_count", flip_count, e.fc);
        chk("flip_mask", flip_mask, e.fm);
      end
    end
  end

  task automatic run_scan(input string nm, input int tx, input int ty, input bit pb, input bit repulse);
    exp_t e;
    logic [1:0] tc;
    int lat, bound;
    bit seen;
    e  = model(bd, tx, ty, pb);
    tc = cell_of(bd, tx, ty);
    bound = tc[1] ? 3 : BOUND;
    exp_q.push_back(e);
    board = bd; x = CW'(tx); y = CW'(ty); player_black = pb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    board = rand_board();
    x = CW'((tx + 1) % N); y = CW'((ty + 3) % N); player_black = ~pb;
    lat = 1; seen = 0;
    for (int c = 0; c < BOUND; c++) begin
      if (c == 0) chk({nm, "_busy_after_start"}, busy, 1);
      start = repulse && (c == 1);
      if (done) begin seen = 1; break; end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, seen, 1);
    if (!seen) begin
      exp_q.delete();
      resetn = 1'b0; @(negedge clk); resetn = 1'b1; @(negedge clk);
    end else begin
      n_cmp++;
      if (lat > bound) begin
        n_bad++;
        $display("FAIL %s_latency: got %0d cycles, required <= %0d", nm, lat, bound);
      end
      // start coinciding with done must be ignored, and done lasts one cycle
      start = 1'b1; x = CW'($urandom_range(0, N-1)); y = CW'($urandom_range(0, N-1));
      @(negedge clk);
      start = 1'b0;
      chk({nm, "_start_at_done_ignored"}, busy, 0);
      chk({nm, "_done_one_cycle"}, done, 0);
    end
  endtask

  task automatic check_lit(input string nm, input bit lv, input logic [7:0] lm, input int lfc);
    chk({nm, "_lit_valid"}, valid, lv);
    chk({nm, "_lit_dir_mask"}, dir_mask, lm);
    chk({nm, "_lit_flip_count"}, flip_count, lfc);
  endtask

  task automatic multi_board();
    bd = '0;
    put(3, 3, WHITE); put(3, 2, WHITE); put(2, 3, WHITE);
    put(4, 4, BLACK); put(4, 2, BLACK); put(2, 4, BLACK);
  endtask

  initial begin
    int tx, ty, lat6;
    bit seen6;
    logic [2*N6*N6-1:0] b6;
    resetn = 1'b0; start = 1'b0; x = '0; y = '0; player_black = 1'b0; board = '0;
    start6 = 1'b0; x6 = '0; y6 = '0; player6 = 1'b0; board6 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", valid, 0);
    chk("reset_dir_mask", dir_mask, 0);
    chk("reset_flip_count", flip_count, 0);
    chk("reset_flip_mask", flip_mask, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Standard opening, black to move at (3,2)
    bd = '0;
    put(3, 3, WHITE); put(4, 4, WHITE); put(3, 4, BLACK); put(4, 3, BLACK);
    run_scan("opening", 3, 2, 1'b1, 1'b0);
    check_lit("opening", 1'b1, 8'b0000_0010, 1);
`ifdef FLIP_MASK_EN
    chk("opening_lit_flip_mask", flip_mask, 64'h0000_0000_0800_0000);
`endif

    // Occupied target
    run_scan("occupied", 3, 3, 1'b1, 1'b0);
    check_lit("occupied", 1'b0, 8'h00, 0);

    // Opponent run reaching the right edge with no capping piece
    bd = '0;
    for (int i = 1; i < N; i++) put(i, 0, WHITE);
    run_scan("edge_row", 0, 0, 1'b1, 1'b0);
    check_lit("edge_row", 1'b0, 8'h00, 0);

    // Three valid directions, with a re-pulsed start mid-scan
    multi_board();
    run_scan("multi", 2, 2, 1'b1, 1'b1);
    check_lit("multi", 1'b1, 8'b1000_1010, 3);

    // Randomized boards, targets and side to move
    for (int k = 0; k < 80; k++) begin
      bd = rand_board();
      tx = $urandom_range(0, N-1);
      ty = $urandom_range(0, N-1);
      if ($urandom_range(0, 3) != 0) put(tx, ty, EMPTY);
      run_scan("random", tx, ty, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a scan
    multi_board();
    board = bd; x = CW'(2); y = CW'(2); player_black = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_valid", valid, 0);
    chk("midreset_dir_mask", dir_mask, 0);
    chk("midreset_flip_count", flip_count, 0);
    chk("midreset_flip_mask", flip_mask, 0);
    exp_q.delete();
    resetn = 1'b1;
    repeat (100) @(negedge clk);

    // N=6 opening, centre at (2,2)/(3,3), black to move at (2,1)
    b6 = '0;
    b6[2*(2*N6+2) +: 2] = WHITE;
    b6[2*(3*N6+3) +: 2] = WHITE;
    b6[2*(3*N6+2) +: 2] = BLACK;
    b6[2*(2*N6+3) +: 2] = BLACK;
    board6 = b6; x6 = CW6'(2); y6 = CW6'(1); player6 = 1'b1; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0; board6 = '0;
    seen6 = 0; lat6 = 1;
    for (int c = 0; c < BOUND6; c++) begin
      if (done6) begin seen6 = 1; break; end
      @(negedge clk);
      lat6++;
    end
    chk("n6_done_seen", seen6, 1);
    chk("n6_valid", valid6, 1);
    chk("n6_dir_mask", dir_mask6, 8'b0000_0010);
    chk("n6_flip_count", flip_count6, 1);
`ifdef FLIP_MASK_EN
    chk("n6_flip_mask", flip_mask6, 64'h0000_0000_0000_4000);
`else
    chk("n6_flip_mask", flip_mask6, 0);
`endif
    @(negedge clk);
    chk("n6_busy_cleared", busy6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
